// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizes for the FIFO write-side arbiter.
// Also intended for a later read-side scheduler.
package fifo_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bus plus FIFO write port for the arbiter.
// The master modport is the arbiter side. The slave modport is the producers plus the FIFO.
interface fifo_wr_arbiter_if
   import fifo_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          fifo_full;
   logic                          fifo_almost_full;
   logic                          busy;
   logic [IDX_W-1:0]              owner;

   modport master (
      input  req, req_data, fifo_full, fifo_almost_full,
      output ack, fifo_wr_en, fifo_wr_data, busy, owner
   );

   modport slave (
      output req, req_data, fifo_full, fifo_almost_full,
      input  ack, fifo_wr_en, fifo_wr_data, busy, owner
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder. It returns the first set request at rr_ptr, rr_ptr+1, and so on, wrapping modulo NUM_REQ.
// NUM_REQ must be a power of two, so the index wraps by plain truncation.
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   always_comb begin
      logic [IDX_W-1:0] cand;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      valid = 1'b0;
      index = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = rr_ptr + IDX_W'(k);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the byte FIFO, with bounded burst locking.
// A write happens in the same cycle that ack is high.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BURST_MAX  = 4
) (
   input logic            clk,
   input logic            rst_n,
   fifo_wr_arbiter_if.master bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX);

   arb_state_e       state, state_n;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
   logic [IDX_W-1:0] owner, owner_n;
   logic [CNT_W-1:0] beat_cnt, beat_n;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             grant;
   logic [IDX_W-1:0] gidx;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .index  (pick_idx)
   );

   always_comb begin
      state_n  = state;
      rr_ptr_n = rr_ptr;
      owner_n  = owner;
      beat_n   = beat_cnt;
      grant    = 1'b0;
      gidx     = owner;
      unique case (state)
         IDLE: begin
            if (!bus.fifo_full && pick_valid) begin
               grant   = 1'b1;
               gidx    = pick_idx;
               owner_n = pick_idx;
               beat_n  = CNT_W'(1);
               if (BURST_MAX > 1 && !bus.fifo_almost_full)
                  state_n = BURST;
               else
                  rr_ptr_n = pick_idx + IDX_W'(1);
            end
         end
         BURST: begin
            // The owner drops its request: release with a one-cycle bubble.
            if (!bus.req[owner]) begin
               state_n  = IDLE;
               rr_ptr_n = owner + IDX_W'(1);
            end else if (bus.fifo_full) begin
               // A full FIFO keeps the lock. Nobody gets an ack this cycle.
            end else if (beat_cnt >= BURST_LAST) begin
               state_n  = IDLE;
               rr_ptr_n = owner + IDX_W'(1);
            end else begin
               grant  = 1'b1;
               beat_n = beat_cnt + CNT_W'(1);
               // Almost-full lets the owner write one final beat.
               if (bus.fifo_almost_full || beat_n == BURST_LAST) begin
                  state_n  = IDLE;
                  rr_ptr_n = owner + IDX_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments, so every flop samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         owner    <= owner_n;
         beat_cnt <= beat_n;
      end
   end

   // The write strobes are gated with rst_n, so they drop as soon as reset asserts.
   always_comb begin
      bus.ack          = '0;
      bus.fifo_wr_data = '0;
      if (grant && rst_n) begin
         bus.ack[gidx]    = 1'b1;
         bus.fifo_wr_data = bus.req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.fifo_wr_en = |bus.ack;
   assign bus.busy       = (state == BURST);
   assign bus.owner      = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_MAX=4).
// Inputs change 1 time unit after posedge. Outputs are sampled 1 time unit later.
module tb_fifo_wr_arbiter;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n                = 1'b0;
      bus.req              = '0;
      bus.fifo_full        = 1'b0;
      bus.fifo_almost_full = 1'b0;
      #1;
      check("rst_ack", 32'(bus.ack), 32'h0);
      check("rst_owner", 32'(bus.owner), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      step();

      // 1: all four requesters active, full bursts in rotation
      do_reset();
      bus.req = 4'b1111;
      for (int g = 0; g < 4; g++) begin
         for (int b = 0; b < 4; b++) begin
            #1;
            check("t1_ack", 32'(bus.ack), 32'(1) << g);
            check("t1_data", 32'(bus.fifo_wr_data), 32'h10 + 32'(g));
            step();
            if (b == 0) check("t1_owner", 32'(bus.owner), 32'(g));
         end
      end
      #1;
      check("t1_wrap", 32'(bus.fifo_wr_data), 32'h10);

      // 2: lone requester drops its request after two beats
      do_reset();
      bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
      bus.req      = 4'b0100;
      for (int b = 0; b < 2; b++) begin
         #1;
         check("t2_data", 32'(bus.fifo_wr_data), 32'hA5);
         step();
      end
      bus.req = 4'b0000;
      #1;
      check("t2_bubble", 32'(bus.fifo_wr_en), 32'h0);
      step();
      check("t2_idle", 32'(bus.busy), 32'h0);
      bus.req = 4'b1111;
      #1;
      check("t2_ptr3", 32'(bus.ack), 32'b1000);

      // 3: FIFO full in the middle of requester 1's burst
      do_reset();
      bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.req      = 4'b0010;
      for (int b = 0; b < 2; b++) begin
         #1;
         check("t3_pre", 32'(bus.ack), 32'b0010);
         step();
      end
      bus.req       = 4'b1011;
      bus.fifo_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t3_full_wr", 32'(bus.fifo_wr_en), 32'h0);
         check("t3_full_busy", 32'(bus.busy), 32'h1);
         check("t3_full_owner", 32'(bus.owner), 32'h1);
         step();
      end
      bus.fifo_full = 1'b0;
      for (int b = 0; b < 2; b++) begin
         #1;
         check("t3_post", 32'(bus.ack), 32'b0010);
         step();
      end
      #1;
      check("t3_next", 32'(bus.ack), 32'b1000);

      // 4: almost-full forces single-beat alternation
      do_reset();
      bus.fifo_almost_full = 1'b1;
      bus.req              = 4'b0011;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("t4_ack", 32'(bus.ack), (c % 2 == 0) ? 32'b0001 : 32'b0010);
         check("t4_busy", 32'(bus.busy), 32'h0);
         step();
      end

      // 5: asynchronous reset in the middle of a burst
      do_reset();
      bus.req = 4'b1111;
      #1;
      check("t5_b1", 32'(bus.ack), 32'b0001);
      step();
      #1;
      check("t5_b2", 32'(bus.ack), 32'b0001);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ack", 32'(bus.ack), 32'h0);
      check("t5_rst_wr", 32'(bus.fifo_wr_en), 32'h0);
      check("t5_rst_busy", 32'(bus.busy), 32'h0);
      step();
      rst_n   = 1'b1;
      bus.req = 4'b0110;
      #1;
      check("t5_first", 32'(bus.ack), 32'b0010);

      // 6: idle period, then a single late requester
      do_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         check("t6_idle_wr", 32'(bus.fifo_wr_en), 32'h0);
         step();
      end
      bus.req = 4'b1000;
      #1;
      check("t6_ack", 32'(bus.ack), 32'b1000);
      check("t6_data", 32'(bus.fifo_wr_data), 32'h13);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the 16-deep byte FIFO between NUM_REQ requesters.
- Supports bounded burst locking: a granted requester keeps the port for up to BURST_MAX consecutive beats.
- Honours the FIFO's full and almost-full status. Sits between on-chip producers and the FIFO write side.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..8)
- DATA_WIDTH, 8, width of each requester data word and of the FIFO write word
- BURST_MAX, 4, maximum consecutive beats per grant (1..15; 1 disables locking)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester write request, level
- req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ack  output  NUM_REQ  one-hot; ack[i]=1 means req_data[i] is written this cycle
- fifo_wr_en  output  1  FIFO write strobe
- fifo_wr_data  output  DATA_WIDTH  FIFO write data
- fifo_full  input  1  FIFO full status
- fifo_almost_full  input  1  FIFO occupancy >= almost-full threshold
- busy  output  1  high while in BURST state
- owner  output  $clog2(NUM_REQ)  current or most recent grantee

Behaviour:
Interface:
- One clock, clk. Reset rst_n is asynchronous and active-low.

Output timing:
- ack, fifo_wr_en and fifo_wr_data are combinational from state, req, req_data and fifo_full. Zero-cycle latency: a write occurs in the cycle ack is high.
- All three are forced to 0 while rst_n=0.
- fifo_wr_en equals |ack. fifo_wr_data equals the acked requester's data, else 0.

Reset values:
- state=IDLE, rr_ptr=0, beat_cnt=0, owner=0, busy=0.

Handshake:
- A requester holds req[i] and req_data[i] stable until ack[i]. Each ack consumes one word.
- req[i] may drop only after an ack or before any grant.

State IDLE:
- If fifo_full=1 or req=0: no write, remain in IDLE.
- Otherwise grant the first set req at index rr_ptr, rr_ptr+1, … (modulo NUM_REQ). Write one beat, set owner=winner and beat_cnt=1.
- If BURST_MAX>1 and fifo_almost_full=0: go to BURST.
- Otherwise set rr_ptr=winner+1 (wrap) and stay in IDLE.

State BURST (busy=1):
- req[owner]=1, fifo_full=0, beat_cnt<BURST_MAX, fifo_almost_full=0: write, beat_cnt++.
- If that write makes beat_cnt==BURST_MAX: rr_ptr=owner+1, go to IDLE.
- fifo_full=1: no write, hold owner, beat_cnt and lock. Other requesters receive no ack.
- req[owner]=0: release. No write this cycle (one bubble), rr_ptr=owner+1, go to IDLE.
- fifo_almost_full=1 with fifo_full=0: one final beat for owner if req[owner]=1, then rr_ptr=owner+1, go to IDLE.

Other rules:
- The pointer advances only on grant completion, which guarantees fairness. No requester waits more than (NUM_REQ-1)*BURST_MAX granted beats.
- beat_cnt is $clog2(BURST_MAX+1) bits wide and never wraps.
- Reset asserted mid-burst: immediate return to reset values. A partial burst is abandoned with no further ack.

Decomposition:
- Package fifo_pkg holds the state enum (IDLE, BURST) and the default DATA_WIDTH and NUM_REQ constants.
- One sub-module, rr_pick: combinational rotate-priority-encoder. Inputs req and rr_ptr; outputs valid and index. It is reusable by a future read-side scheduler.

Test Plan:
1. Reset, then req=4'b1111 with data 0x10,0x11,0x12,0x13, never full.
   -> Beats 0x10 x4, then 0x11 x4, 0x12 x4, 0x13 x4, then back to 0x10. owner sequence 0,1,2,3.
2. req=4'b0100 only, data 0xA5, req dropped after 2 acks.
   -> Two writes of 0xA5, one bubble cycle, state IDLE, rr_ptr=3.
3. Mid-burst on requester 1 (beat_cnt=2), fifo_full=1 for 3 cycles while req=4'b1011.
   -> No ack and fifo_wr_en=0 for 3 cycles, busy=1, owner=1. After full clears, 2 more beats from 1, then grant 3.
4. fifo_almost_full=1, req=4'b0011.
   -> Single-beat alternation: 0,1,0,1. busy never high.
5. Assert rst_n=0 asynchronously mid-burst between clock edges.
   -> ack=0, fifo_wr_en=0 immediately. After release, first grant goes to the lowest set req starting at index 0.
6. req=0 for 10 cycles, then req=4'b1000.
   -> No writes while idle, then requester 3 is granted in the first cycle its request is seen.
